// File: rtl/lut_neuron_rw.sv
// lut_neuron_rw: runtime-writable LogicNets neuron truth table.
// The table lives in distributed RAM (asynchronous read), one column per
// output bit. A single output register gives a one-cycle, back-pressured
// lookup. A small IDLE/CLEAR sequencer zeroes every entry on request.
module lut_neuron_rw #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_BITS-1:0] out_data,
   input  logic                cfg_we,
   input  logic [IN_BITS-1:0]  cfg_addr,
   input  logic [OUT_BITS-1:0] cfg_wdata,
   input  logic                cfg_clear,
   output logic                cfg_busy
);

   localparam int                 DEPTH    = 1 << IN_BITS;
   localparam logic [IN_BITS-1:0] LAST_IDX = {IN_BITS{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Sequencer and output registers
   state_t              r_state;
   logic [IN_BITS-1:0]  r_clr_cnt;
   logic                r_busy;
   logic                r_out_valid;
   logic [OUT_BITS-1:0] r_out_data;

   // Table write port and lookup datapath
   logic                w_tab_we;
   logic [IN_BITS-1:0]  w_tab_addr;
   logic [OUT_BITS-1:0] w_tab_wdata;
   logic [OUT_BITS-1:0] w_rd_data;
   logic                w_in_ready;
   logic                w_accept;

   // in_ready depends only on registered state and out_ready, never on in_valid.
   assign w_in_ready = !r_busy && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;

   // Select the single table write source: clear sequencer first, then host writes.
   // Nothing is written on a reset edge, so an aborted clear leaves the
   // remaining entries untouched. A host write coinciding with a clear
   // request is dropped.
   always_comb begin
      w_tab_we    = 1'b0;
      w_tab_addr  = cfg_addr;
      w_tab_wdata = cfg_wdata;
      if (!rst_n) begin
         w_tab_we = 1'b0;
      end else if (r_state == ST_CLEAR) begin
         w_tab_we    = 1'b1;
         w_tab_addr  = r_clr_cnt;
         w_tab_wdata = '0;
      end else if (cfg_we && !cfg_clear) begin
         w_tab_we = 1'b1;
      end
   end

   // One single-bit RAM column per output bit; reads are asynchronous so a
   // same-cycle write is not seen by the lookup captured at that edge.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_BITS; gi++) begin : g_col
         logic r_col [DEPTH];

         // Column write; contents are deliberately not reset.
         always_ff @(posedge clk) begin
            if (w_tab_we) begin
               r_col[w_tab_addr] <= w_tab_wdata[gi];
            end
         end

         assign w_rd_data[gi] = r_col[in_data];
      end
   endgenerate

   // Clear sequencer: walk every index once, ignoring repeat clear requests.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_clr_cnt <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cfg_clear) begin
                  r_state   <= ST_CLEAR;
                  r_clr_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (r_clr_cnt == LAST_IDX) begin
                  r_state   <= ST_IDLE;
                  r_clr_cnt <= '0;
                  r_busy    <= 1'b0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + IN_BITS'(1);
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_clr_cnt <= '0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   // Output register: load on acceptance, drain when consumed, hold while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_rd_data;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign cfg_busy  = r_busy;

endmodule
